// File: rtl/control_unit_types_pkg.sv
// -----------------------------------------------------------------------------
// control_unit_types_pkg
// Shared types for the pipeline control logic.
//   pctrl_state_t : sequencing state of pipeline_ctrl (RUN, DWAIT, HALT)
//   pctrl_cause_t : which priority level is driving the latch controls
//   pctrl_ctrl_t  : bundle of PC enable plus the four latch enables/flushes
//   pctrl_decode  : maps a cause onto its latch control bundle
// -----------------------------------------------------------------------------
package control_unit_types_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DWAIT = 2'd1,
    HALT  = 2'd2
  } pctrl_state_t;

  // Ordered highest priority first.
  typedef enum logic [2:0] {
    PRI_HALT    = 3'd0,
    PRI_DSTALL  = 3'd1,
    PRI_BRANCH  = 3'd2,
    PRI_LOADUSE = 3'd3,
    PRI_FETCH   = 3'd4,
    PRI_NONE    = 3'd5
  } pctrl_cause_t;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmm_en;
    logic mmwb_en;
    logic ifid_flush;
    logic idex_flush;
    logic exmm_flush;
    logic mmwb_flush;
  } pctrl_ctrl_t;

  function automatic pctrl_ctrl_t pctrl_decode(input pctrl_cause_t cause);
    pctrl_ctrl_t c;
    c = '0;
    case (cause)
      PRI_HALT: begin
        // Everything frozen; c stays all-zero.
      end
      PRI_DSTALL: begin
        // Front of the pipe holds; WB gets a bubble so the retiring
        // instruction is not written back twice.
        c.mmwb_en    = 1'b1;
        c.mmwb_flush = 1'b1;
      end
      PRI_BRANCH: begin
        // PC takes the target; the three younger wrong-path slots are squashed.
        c.pc_en      = 1'b1;
        c.ifid_en    = 1'b1;
        c.idex_en    = 1'b1;
        c.exmm_en    = 1'b1;
        c.mmwb_en    = 1'b1;
        c.ifid_flush = 1'b1;
        c.idex_flush = 1'b1;
        c.exmm_flush = 1'b1;
      end
      PRI_LOADUSE: begin
        // Hold PC and ID, push a bubble into EX behind the load.
        c.idex_en    = 1'b1;
        c.exmm_en    = 1'b1;
        c.mmwb_en    = 1'b1;
        c.idex_flush = 1'b1;
      end
      PRI_FETCH: begin
        // No instruction arrived: hold PC, feed a bubble into ID.
        c.ifid_en    = 1'b1;
        c.idex_en    = 1'b1;
        c.exmm_en    = 1'b1;
        c.mmwb_en    = 1'b1;
        c.ifid_flush = 1'b1;
      end
      default: begin
        c.pc_en   = 1'b1;
        c.ifid_en = 1'b1;
        c.idex_en = 1'b1;
        c.exmm_en = 1'b1;
        c.mmwb_en = 1'b1;
      end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// -----------------------------------------------------------------------------
// hazard_detect
// Purely combinational load-use hazard detection between EX and ID.
// Ports:
//   idex_dREN    in  1  instruction in EX is a load
//   idex_rd      in  5  destination register of the EX instruction
//   ifid_rs      in  5  rs of the ID instruction
//   ifid_rt      in  5  rt of the ID instruction
//   ifid_rt_used in  1  ID instruction actually reads rt
//   lu_hazard    out 1  ID needs the load result before it is available
// -----------------------------------------------------------------------------
module hazard_detect (
  input  logic       idex_dREN,
  input  logic [4:0] idex_rd,
  input  logic [4:0] ifid_rs,
  input  logic [4:0] ifid_rt,
  input  logic       ifid_rt_used,
  output logic       lu_hazard
);

  logic rs_match;
  logic rt_match;

  assign rs_match = (idex_rd == ifid_rs);
  assign rt_match = ifid_rt_used & (idex_rd == ifid_rt);

  // r0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign lu_hazard = idex_dREN & (idex_rd != 5'd0) & (rs_match | rt_match);

endmodule

// File: rtl/pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl
// Hazard and sequencing controller for the five-stage pipeline. Produces the
// PC enable and the enable/flush pair of each inter-stage latch every cycle,
// latches processor halt and keeps saturating stall/flush counters.
// Parameters:
//   CNTW  width of the performance counters
// Ports:
//   CLK, nRST                 clock, asynchronous active-low reset
//   ihit, dhit                instruction / data cache handshakes
//   exmm_dREN, exmm_dWEN      load / store in MEM
//   exmm_branch_taken         branch in MEM resolved taken
//   mmwb_halt                 halt instruction in WB
//   idex_dREN, idex_rd        load in EX and its destination
//   ifid_rs, ifid_rt,
//   ifid_rt_used              source operands of the ID instruction
//   pc_en                     PC update enable (combinational)
//   *_en, *_flush             latch enables / synchronous clears (combinational)
//   halt                      processor halted (registered)
//   stall_cnt                 non-halted cycles with pc_en=0 (saturating)
//   flush_cnt                 taken-branch flush cycles (saturating)
// -----------------------------------------------------------------------------
module pipeline_ctrl
  import control_unit_types_pkg::*;
#(
  parameter int CNTW = 16
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic            ihit,
  input  logic            dhit,
  input  logic            exmm_dREN,
  input  logic            exmm_dWEN,
  input  logic            exmm_branch_taken,
  input  logic            mmwb_halt,
  input  logic            idex_dREN,
  input  logic [4:0]      idex_rd,
  input  logic [4:0]      ifid_rs,
  input  logic [4:0]      ifid_rt,
  input  logic            ifid_rt_used,
  output logic            pc_en,
  output logic            ifid_en,
  output logic            idex_en,
  output logic            exmm_en,
  output logic            mmwb_en,
  output logic            ifid_flush,
  output logic            idex_flush,
  output logic            exmm_flush,
  output logic            mmwb_flush,
  output logic            halt,
  output logic [CNTW-1:0] stall_cnt,
  output logic [CNTW-1:0] flush_cnt
);

  pctrl_state_t state_q;
  pctrl_cause_t cause;
  pctrl_ctrl_t  ctrl;
  logic         lu_hazard;
  logic         memreq;
  logic         dstall;

  hazard_detect u_hazard_detect (
    .idex_dREN    (idex_dREN),
    .idex_rd      (idex_rd),
    .ifid_rs      (ifid_rs),
    .ifid_rt      (ifid_rt),
    .ifid_rt_used (ifid_rt_used),
    .lu_hazard    (lu_hazard)
  );

  assign memreq = exmm_dREN | exmm_dWEN;
  // A hit in the same cycle the request appears completes it with no stall.
  assign dstall = memreq & ~dhit;

  // NOTE: every always_comb target gets a default before any branch so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    cause = PRI_NONE;
    if (state_q == HALT)        cause = PRI_HALT;
    else if (dstall)            cause = PRI_DSTALL;
    else if (exmm_branch_taken) cause = PRI_BRANCH;
    else if (lu_hazard)         cause = PRI_LOADUSE;
    else if (!ihit)             cause = PRI_FETCH;

    ctrl = pctrl_decode(cause);
    // Latches must not move while the core is held in reset.
    if (!nRST) ctrl = '0;
  end

  assign pc_en      = ctrl.pc_en;
  assign ifid_en    = ctrl.ifid_en;
  assign idex_en    = ctrl.idex_en;
  assign exmm_en    = ctrl.exmm_en;
  assign mmwb_en    = ctrl.mmwb_en;
  assign ifid_flush = ctrl.ifid_flush;
  assign idex_flush = ctrl.idex_flush;
  assign exmm_flush = ctrl.exmm_flush;
  assign mmwb_flush = ctrl.mmwb_flush;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= RUN;
      halt      <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      // A halt whose WB slot is being bubbled this cycle is not retired yet.
      if (state_q != HALT && mmwb_halt && !ctrl.mmwb_flush) begin
        state_q <= HALT;
        halt    <= 1'b1;
      end else begin
        case (state_q)
          RUN:     if (dstall) state_q <= DWAIT;
          DWAIT:   if (dhit)   state_q <= RUN;
          default: state_q <= state_q;
        endcase
      end

      if (state_q != HALT && !ctrl.pc_en && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNTW'(1);

      if (cause == PRI_BRANCH && flush_cnt != '1)
        flush_cnt <= flush_cnt + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_ctrl
// Directed testbench for pipeline_ctrl. Control outputs are packed into
// ctl = {pc_en, ifid_en, idex_en, exmm_en, mmwb_en,
//        ifid_flush, idex_flush, exmm_flush, mmwb_flush}
// and compared against hand-written constants; bits the design leaves free
// (an enable whose latch is being flushed anyway) are masked off.
// -----------------------------------------------------------------------------
module tb_pipeline_ctrl;
  import control_unit_types_pkg::*;

  localparam int CNTW = 8;

  logic            CLK;
  logic            nRST;
  logic            ihit, dhit;
  logic            exmm_dREN, exmm_dWEN, exmm_branch_taken, mmwb_halt;
  logic            idex_dREN;
  logic [4:0]      idex_rd, ifid_rs, ifid_rt;
  logic            ifid_rt_used;
  logic            pc_en, ifid_en, idex_en, exmm_en, mmwb_en;
  logic            ifid_flush, idex_flush, exmm_flush, mmwb_flush;
  logic            halt;
  logic [CNTW-1:0] stall_cnt, flush_cnt;

  logic [8:0] ctl;
  assign ctl = {pc_en, ifid_en, idex_en, exmm_en, mmwb_en,
                ifid_flush, idex_flush, exmm_flush, mmwb_flush};

  localparam logic [8:0] CTL_OFF    = 9'b0_0000_0000;
  localparam logic [8:0] CTL_RUN    = 9'b1_1111_0000;
  localparam logic [8:0] CTL_DSTALL = 9'b0_0001_0001;
  localparam logic [8:0] EXP_LU     = 9'b0_0011_0100;
  localparam logic [8:0] MSK_LU     = 9'b1_1011_1111;
  localparam logic [8:0] EXP_FETCH  = 9'b0_0111_1000;
  localparam logic [8:0] MSK_FETCH  = 9'b1_0111_1111;
  localparam logic [8:0] EXP_BR     = 9'b1_0001_1110;
  localparam logic [8:0] MSK_BR     = 9'b1_0001_1111;

  int n_checks = 0;
  int n_fail   = 0;
  logic [CNTW-1:0] exp_stall;
  logic [CNTW-1:0] exp_flush;

  pipeline_ctrl #(.CNTW(CNTW)) dut (
    .CLK               (CLK),
    .nRST              (nRST),
    .ihit              (ihit),
    .dhit              (dhit),
    .exmm_dREN         (exmm_dREN),
    .exmm_dWEN         (exmm_dWEN),
    .exmm_branch_taken (exmm_branch_taken),
    .mmwb_halt         (mmwb_halt),
    .idex_dREN         (idex_dREN),
    .idex_rd           (idex_rd),
    .ifid_rs           (ifid_rs),
    .ifid_rt           (ifid_rt),
    .ifid_rt_used      (ifid_rt_used),
    .pc_en             (pc_en),
    .ifid_en           (ifid_en),
    .idex_en           (idex_en),
    .exmm_en           (exmm_en),
    .mmwb_en           (mmwb_en),
    .ifid_flush        (ifid_flush),
    .idex_flush        (idex_flush),
    .exmm_flush        (exmm_flush),
    .mmwb_flush        (mmwb_flush),
    .halt              (halt),
    .stall_cnt         (stall_cnt),
    .flush_cnt         (flush_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance past the next rising edge; registered outputs are stable here.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    ihit = 1'b1; dhit = 1'b0;
    exmm_dREN = 1'b0; exmm_dWEN = 1'b0; exmm_branch_taken = 1'b0;
    mmwb_halt = 1'b0; idex_dREN = 1'b0;
    idex_rd = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0; ifid_rt_used = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    nRST = 1'b0;
    #3;
    n_checks++;
    if (ctl !== CTL_OFF) begin
      n_fail++; $display("FAIL reset_ctl: got %b expected %b", ctl, CTL_OFF);
    end
    n_checks++;
    if (halt !== 1'b0 || stall_cnt !== '0 || flush_cnt !== '0) begin
      n_fail++; $display("FAIL reset_regs: halt=%b stall=%0d flush=%0d expected 0/0/0",
                         halt, stall_cnt, flush_cnt);
    end
    n_checks++;
    if (dut.state_q !== RUN) begin
      n_fail++; $display("FAIL reset_state: got %0d expected RUN", dut.state_q);
    end
    tick();
    nRST = 1'b1;
    #1;
    n_checks++;
    if (ctl !== CTL_RUN) begin
      n_fail++; $display("FAIL post_reset_ctl: got %b expected %b", ctl, CTL_RUN);
    end
    tick();
    exp_stall = '0;
    exp_flush = '0;
  endtask

  task automatic test_load_use();
    // rs match
    idle(); idex_dREN = 1'b1; idex_rd = 5'd5; ifid_rs = 5'd5; #1;
    n_checks++;
    if ((ctl & MSK_LU) !== EXP_LU) begin
      n_fail++; $display("FAIL lu_rs_ctl: got %b expected %b", ctl, EXP_LU);
    end
    tick(); exp_stall = exp_stall + 1;
    n_checks++;
    if (stall_cnt !== exp_stall) begin
      n_fail++; $display("FAIL lu_rs_stall_cnt: got %0d expected %0d", stall_cnt, exp_stall);
    end
    // r0 destination never stalls
    idle(); idex_dREN = 1'b1; idex_rd = 5'd0; ifid_rs = 5'd0; #1;
    n_checks++;
    if (ctl !== CTL_RUN) begin
      n_fail++; $display("FAIL lu_r0_ctl: got %b expected %b", ctl, CTL_RUN);
    end
    tick();
    n_checks++;
    if (stall_cnt !== exp_stall) begin
      n_fail++; $display("FAIL lu_r0_stall_cnt: got %0d expected %0d", stall_cnt, exp_stall);
    end
    // rt match only counts when rt is read
    idle(); idex_dREN = 1'b1; idex_rd = 5'd7; ifid_rs = 5'd3; ifid_rt = 5'd7;
    ifid_rt_used = 1'b1; #1;
    n_checks++;
    if ((ctl & MSK_LU) !== EXP_LU) begin
      n_fail++; $display("FAIL lu_rt_ctl: got %b expected %b", ctl, EXP_LU);
    end
    ifid_rt_used = 1'b0; #1;
    n_checks++;
    if (ctl !== CTL_RUN) begin
      n_fail++; $display("FAIL lu_rt_unused_ctl: got %b expected %b", ctl, CTL_RUN);
    end
    // load not in EX: same register match is harmless
    idex_dREN = 1'b0; ifid_rt_used = 1'b1; #1;
    n_checks++;
    if (ctl !== CTL_RUN) begin
      n_fail++; $display("FAIL lu_noload_ctl: got %b expected %b", ctl, CTL_RUN);
    end
    tick();
  endtask

  task automatic test_fetch_wait();
    idle(); ihit = 1'b0; #1;
    n_checks++;
    if ((ctl & MSK_FETCH) !== EXP_FETCH) begin
      n_fail++; $display("FAIL fetch_ctl: got %b expected %b", ctl, EXP_FETCH);
    end
    tick(); exp_stall = exp_stall + 1;
    n_checks++;
    if (stall_cnt !== exp_stall) begin
      n_fail++; $display("FAIL fetch_stall_cnt: got %0d expected %0d", stall_cnt, exp_stall);
    end
  endtask

  task automatic test_dstall();
    idle(); exmm_dREN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      // Fetch miss during a data stall: ifid must be held, not flushed.
      ihit = (i == 1) ? 1'b0 : 1'b1;
      #1;
      n_checks++;
      if (ctl !== CTL_DSTALL) begin
        n_fail++; $display("FAIL dstall_ctl[%0d]: got %b expected %b", i, ctl, CTL_DSTALL);
      end
      tick(); exp_stall = exp_stall + 1;
      n_checks++;
      if (dut.state_q !== DWAIT) begin
        n_fail++; $display("FAIL dstall_state[%0d]: got %0d expected DWAIT", i, dut.state_q);
      end
    end
    ihit = 1'b1; dhit = 1'b1; #1;
    n_checks++;
    if (ctl !== CTL_RUN) begin
      n_fail++; $display("FAIL dhit_ctl: got %b expected %b", ctl, CTL_RUN);
    end
    tick();
    n_checks++;
    if (dut.state_q !== RUN || stall_cnt !== exp_stall) begin
      n_fail++; $display("FAIL dhit_done: state=%0d stall=%0d expected RUN/%0d",
                         dut.state_q, stall_cnt, exp_stall);
    end
  endtask

  task automatic test_dhit_same_cycle();
    idle(); exmm_dWEN = 1'b1; dhit = 1'b1; #1;
    n_checks++;
    if (ctl !== CTL_RUN) begin
      n_fail++; $display("FAIL sameclk_ctl: got %b expected %b", ctl, CTL_RUN);
    end
    tick();
    n_checks++;
    if (dut.state_q !== RUN || stall_cnt !== exp_stall) begin
      n_fail++; $display("FAIL sameclk_regs: state=%0d stall=%0d expected RUN/%0d",
                         dut.state_q, stall_cnt, exp_stall);
    end
  endtask

  task automatic test_branch();
    // Branch overrides both fetch miss and load-use.
    idle(); exmm_branch_taken = 1'b1; ihit = 1'b0;
    idex_dREN = 1'b1; idex_rd = 5'd9; ifid_rs = 5'd9; #1;
    n_checks++;
    if ((ctl & MSK_BR) !== EXP_BR) begin
      n_fail++; $display("FAIL branch_ctl: got %b expected %b", ctl, EXP_BR);
    end
    tick(); exp_flush = exp_flush + 1;
    n_checks++;
    if (flush_cnt !== exp_flush || stall_cnt !== exp_stall) begin
      n_fail++; $display("FAIL branch_cnt: flush=%0d stall=%0d expected %0d/%0d",
                         flush_cnt, stall_cnt, exp_flush, exp_stall);
    end
    // Data stall outranks a taken branch.
    idle(); exmm_branch_taken = 1'b1; exmm_dREN = 1'b1; #1;
    n_checks++;
    if (ctl !== CTL_DSTALL) begin
      n_fail++; $display("FAIL branch_vs_dstall: got %b expected %b", ctl, CTL_DSTALL);
    end
    dhit = 1'b1; #1;
    n_checks++;
    if ((ctl & MSK_BR) !== EXP_BR) begin
      n_fail++; $display("FAIL branch_after_dhit: got %b expected %b", ctl, EXP_BR);
    end
    tick(); exp_flush = exp_flush + 1;
    n_checks++;
    if (flush_cnt !== exp_flush) begin
      n_fail++; $display("FAIL branch_cnt2: got %0d expected %0d", flush_cnt, exp_flush);
    end
  endtask

  task automatic test_halt_blocked();
    // WB slot is being bubbled, so the halt is not taken this cycle.
    idle(); mmwb_halt = 1'b1; exmm_dREN = 1'b1;
    tick(); exp_stall = exp_stall + 1;
    n_checks++;
    if (halt !== 1'b0 || dut.state_q !== DWAIT) begin
      n_fail++; $display("FAIL halt_blocked: halt=%b state=%0d expected 0/DWAIT",
                         halt, dut.state_q);
    end
    idle(); dhit = 1'b1;
    tick();
  endtask

  task automatic test_reset_dwait();
    idle(); exmm_dREN = 1'b1;
    tick();
    n_checks++;
    if (dut.state_q !== DWAIT) begin
      n_fail++; $display("FAIL rst_dwait_enter: got %0d expected DWAIT", dut.state_q);
    end
    #2 nRST = 1'b0;
    #1;
    n_checks++;
    if (ctl !== CTL_OFF || stall_cnt !== '0 || flush_cnt !== '0 || dut.state_q !== RUN) begin
      n_fail++; $display("FAIL rst_dwait_async: ctl=%b stall=%0d flush=%0d state=%0d expected %b/0/0/RUN",
                         ctl, stall_cnt, flush_cnt, dut.state_q, CTL_OFF);
    end
    idle();
    #1 nRST = 1'b1;
    #1;
    n_checks++;
    if (ctl !== CTL_RUN || dut.state_q !== RUN) begin
      n_fail++; $display("FAIL rst_dwait_release: ctl=%b state=%0d expected %b/RUN",
                         ctl, dut.state_q, CTL_RUN);
    end
    exp_stall = '0;
    exp_flush = '0;
    tick();
  endtask

  task automatic test_halt();
    idle(); mmwb_halt = 1'b1; #1;
    n_checks++;
    if (halt !== 1'b0 || ctl !== CTL_RUN) begin
      n_fail++; $display("FAIL halt_pre: halt=%b ctl=%b expected 0/%b", halt, ctl, CTL_RUN);
    end
    tick();
    n_checks++;
    if (halt !== 1'b1 || ctl !== CTL_OFF) begin
      n_fail++; $display("FAIL halt_entry: halt=%b ctl=%b expected 1/%b", halt, ctl, CTL_OFF);
    end
    // Nothing moves and nothing counts while halted.
    idle(); ihit = 1'b0; exmm_dREN = 1'b1; exmm_branch_taken = 1'b1;
    for (int i = 0; i < 4; i++) begin
      dhit = i[0];
      #1;
      n_checks++;
      if (ctl !== CTL_OFF || halt !== 1'b1) begin
        n_fail++; $display("FAIL halt_hold[%0d]: ctl=%b halt=%b expected %b/1", i, ctl, halt, CTL_OFF);
      end
      tick();
    end
    n_checks++;
    if (stall_cnt !== exp_stall || flush_cnt !== exp_flush || dut.state_q !== HALT) begin
      n_fail++; $display("FAIL halt_counters: stall=%0d flush=%0d state=%0d expected %0d/%0d/HALT",
                         stall_cnt, flush_cnt, dut.state_q, exp_stall, exp_flush);
    end
    idle(); nRST = 1'b0; #1;
    n_checks++;
    if (halt !== 1'b0) begin
      n_fail++; $display("FAIL halt_clear: got %b expected 0", halt);
    end
    tick(); nRST = 1'b1; #1;
    n_checks++;
    if (ctl !== CTL_RUN) begin
      n_fail++; $display("FAIL halt_restart: got %b expected %b", ctl, CTL_RUN);
    end
    exp_stall = '0;
    exp_flush = '0;
    tick();
  endtask

  task automatic test_saturation();
    idle(); ihit = 1'b0;
    for (int i = 0; i < 255; i++) tick();
    n_checks++;
    if (stall_cnt !== 8'hFF) begin
      n_fail++; $display("FAIL sat_reach: got %0d expected 255", stall_cnt);
    end
    for (int i = 0; i < 6; i++) tick();
    n_checks++;
    if (stall_cnt !== 8'hFF) begin
      n_fail++; $display("FAIL sat_hold: got %0d expected 255", stall_cnt);
    end
    idle();
  endtask

  initial begin
    exp_stall = '0;
    exp_flush = '0;
    test_reset();
    test_load_use();
    test_fetch_wait();
    test_dstall();
    test_dhit_same_cycle();
    test_branch();
    test_halt_blocked();
    test_reset_dwait();
    test_halt();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Hazard and sequencing controller for the five-stage MIPS pipeline. Each cycle it generates the enable and flush controls for the four inter-stage latches (ifid, idex, exmm, mmwb) and the PC enable. Inputs are cache handshakes, load-use hazards and branches resolved in MEM. It also latches processor halt and keeps saturating stall and flush counters for performance readout.

## Interface
Parameters:
- CNTW, 16, width of the performance counters

Ports:
- CLK  in  1  clock
- nRST  in  1  asynchronous active-low reset
- ihit  in  1  instruction cache returned a valid instruction this cycle
- dhit  in  1  data cache completed the outstanding access this cycle
- exmm_dREN  in  1  load in MEM stage (exmm latch output)
- exmm_dWEN  in  1  store in MEM stage
- exmm_branch_taken  in  1  branch/jump in MEM resolved taken
- mmwb_halt  in  1  halt instruction in WB stage
- idex_dREN  in  1  instruction in EX is a load
- idex_rd  in  5  destination register of instruction in EX
- ifid_rs  in  5  rs of instruction in ID
- ifid_rt  in  5  rt of instruction in ID
- ifid_rt_used  in  1  ID instruction reads rt
- pc_en  out  1  PC register update enable
- ifid_en, idex_en, exmm_en, mmwb_en  out  1 each  latch update enables
- ifid_flush, idex_flush, exmm_flush, mmwb_flush  out  1 each  synchronous clear of latch (bubble insert)
- halt  out  1  processor halted (registered)
- stall_cnt  out  CNTW  cycles with pc_en=0 while not halted
- flush_cnt  out  CNTW  taken-branch flush events

## Operation
- State register: RUN, DWAIT, HALT. Reset → RUN, halt=0, both counters 0.
- memreq = exmm_dREN | exmm_dWEN. lu_hazard = idex_dREN & idex_rd≠0 & (idex_rd==ifid_rs | (ifid_rt_used & idex_rd==ifid_rt)).
- Transitions: RUN→DWAIT when memreq & ~dhit. DWAIT→RUN on dhit. Any state→HALT when mmwb_halt=1 and the mmwb latch is not being flushed. HALT is exited only by reset.
- Output priority, highest first:
  1. HALT: all en=0, all flush=0, pc_en=0.
  2. Data stall (memreq & ~dhit, in RUN or DWAIT): pc_en=0; ifid/idex/exmm en=0; mmwb_en=1 with mmwb_flush=1, giving a bubble so WB does not repeat.
  3. Taken branch (exmm_branch_taken): pc_en=1, PC loads the target; ifid/idex/exmm flush=1; mmwb_en=1. This overrides ihit=0 and lu_hazard.
  4. Load-use (lu_hazard): pc_en=0, ifid_en=0, idex_flush=1; exmm/mmwb en=1.
  5. Fetch wait (~ihit): pc_en=0, ifid_flush=1; idex/exmm/mmwb en=1.
  6. Otherwise all en=1, all flush=0, pc_en=1.
- A flush takes effect regardless of the matching en. The latch is cleared on the next edge.
- Counters saturate at all-ones and never wrap. stall_cnt increments in every non-HALT cycle with pc_en=0. flush_cnt increments once per cycle of priority 3.
- While nRST=0: all en=0, all flush=0, pc_en=0.

## Timing
- All en, flush and pc_en outputs are combinational from the current state and inputs, with zero-cycle latency to the latch edges.
- halt, the state and the counters are registered and update on the CLK rising edge. halt goes high the cycle after mmwb_halt is seen.
- dhit arriving in the same cycle memreq is first seen: no DWAIT entry and no stall.
- ihit=0 and a data stall together: the data stall wins and ifid is held, not flushed.
- Reset asserted mid-DWAIT: the state returns to RUN immediately (asynchronously), and an in-flight access is abandoned.

## Structure
- Add pctrl_state_t (RUN, DWAIT, HALT) to control_unit_types_pkg.
- One sub-module, hazard_detect: purely combinational lu_hazard from idex_dREN, idex_rd, ifid_rs, ifid_rt and ifid_rt_used.
- The FSM, priority mux and counters live in pipeline_ctrl.

## Test plan
- Load r5 in EX, ID reads rs=5: pc_en=0, ifid_en=0, idex_flush=1 for 1 cycle; stall_cnt 0→1. Repeat with idex_rd=0: no stall.
- exmm_dREN=1, dhit low for 3 cycles: state DWAIT, mmwb_flush=1 and all other en=0 for 3 cycles. dhit on cycle 4: all en=1, state RUN, stall_cnt=3.
- exmm_branch_taken=1 with ihit=0 and lu_hazard=1: pc_en=1, ifid/idex/exmm flush=1, flush_cnt+1.
- mmwb_halt=1: halt=1 next cycle, all en=0 thereafter regardless of ihit/dhit. Only nRST clears it.
- Hold ihit=0 for 2^CNTW+5 cycles: stall_cnt saturates at all-ones.
- Assert nRST low during DWAIT: outputs and counters at reset values immediately; after release, state RUN with all en=1 given ihit=1.
